apb_mem_slave: RTL and testbench



---
 rtl/apb_mem_slave.sv | 177 +++++++++++++++++
 tb/tb_apb_mem_slave.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
`default_nettype none
// =============================================================================
// apb_mem_slave : APB completer backed by a DEPTH-word register file with PSLVERR
//                 on out-of-range addresses; APB_SLAVE_WAIT_EN adds wait states.
// Revision      : 1.0
// =============================================================================
module apb_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef APB_SLAVE_WAIT_EN
    WAIT = 2'd2,
`endif
    RESP = 2'd1
  } state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_nxt;
  logic                  pready_q, pready_nxt;
  logic                  pslverr_q, pslverr_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef APB_SLAVE_WAIT_EN
  logic [3:0]            cnt, cnt_nxt;
`endif

  logic                  setup;
  logic                  setup_err;
  logic [IDX_W-1:0]      setup_idx;
  logic                  mem_we;
  logic                  load;
  logic                  resp_now;
  logic [IDX_W-1:0]      resp_idx;
  logic                  resp_write;
  logic                  resp_err;
  logic [DATA_WIDTH-1:0] rd_word;

  assign setup     = PSEL && !PENABLE;
  assign setup_err = (PADDR >= DEPTH_A);
  assign setup_idx = PADDR[IDX_W-1:0];
  assign mem_we    = (state == RESP) && PSEL && PENABLE && pready_q && write_q && !err_q;

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    resp_now    = 1'b0;
    resp_idx    = addr_q;
    resp_write  = write_q;
    resp_err    = err_q;
    pready_nxt  = 1'b0;
    pslverr_nxt = 1'b0;
    prdata_nxt  = prdata_q;
`ifdef APB_SLAVE_WAIT_EN
    cnt_nxt     = cnt;
`endif

    // RESP doubles as IDLE for setup detection so back-to-back setups lose no cycle.
    if ((state == IDLE || state == RESP) && setup) begin
      load       = 1'b1;
      resp_idx   = setup_idx;
      resp_write = PWRITE;
      resp_err   = setup_err;
`ifdef APB_SLAVE_WAIT_EN
      cnt_nxt = 4'(WAIT_CYCLES);
      if (WAIT_CYCLES != 0) begin
        state_nxt = WAIT;
      end else begin
        state_nxt = RESP;
        resp_now  = 1'b1;
      end
`else
      state_nxt = RESP;
      resp_now  = 1'b1;
`endif
    end else begin
      case (state)
`ifdef APB_SLAVE_WAIT_EN
        WAIT: begin
          if (!PSEL) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end else if (cnt <= 4'd1) begin
            state_nxt = RESP;
            resp_now  = 1'b1;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
`endif
        RESP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end

    // Forward a write committing on this same edge to a read of that word.
    rd_word = mem[resp_idx];
    if (mem_we && (addr_q == resp_idx)) begin
      rd_word = wdata_q;
    end

    if (resp_now) begin
      pready_nxt  = 1'b1;
      pslverr_nxt = resp_err;
      prdata_nxt  = (resp_write || resp_err) ? '0 : rd_word;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB_SLAVE_WAIT_EN
      cnt       <= 4'd0;
`endif
    end else begin
      state     <= state_nxt;
      prdata_q  <= prdata_nxt;
      pready_q  <= pready_nxt;
      pslverr_q <= pslverr_nxt;
`ifdef APB_SLAVE_WAIT_EN
      cnt       <= cnt_nxt;
`endif
      if (load) begin
        addr_q  <= setup_idx;
        write_q <= PWRITE;
        wdata_q <= PWDATA;
        err_q   <= setup_err;
      end
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
`default_nettype none
// tb_apb_mem_slave : randomized APB transfers checked against a word-array reference model.
module tb_apb_mem_slave;

  localparam int DEPTH = 16;
`ifdef APB_SLAVE_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif

  logic        PCLK    = 1'b0;
  logic        PRESETn = 1'b1;
  logic        PSEL    = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE  = 1'b0;
  logic [31:0] PADDR   = 32'h0;
  logic [31:0] PWDATA  = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model [DEPTH];

  always #5 PCLK = ~PCLK;

  apb_mem_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(2)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR)
  );

  function automatic logic in_range(input logic [31:0] a);
    return a < 32'(DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return in_range(a) ? model[a[3:0]] : 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  // One complete transfer; called at posedge+1. hold keeps PSEL up for an immediate next setup.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic hold,
                      output logic [31:0] rd, output logic er, output int lat, output logic setup_rdy);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(negedge PCLK);
    setup_rdy = PREADY;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    lat = 0;
    @(negedge PCLK);
    while (!PREADY && lat < 40) begin
      lat++;
      PADDR  = $urandom;
      PWDATA = $urandom;
      @(negedge PCLK);
    end
    rd = PRDATA;
    er = PSLVERR;
    @(posedge PCLK); #1;
    if (!hold) begin
      PSEL = 1'b0; PENABLE = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lat; logic sr;
    model_clear();
    vectors++;
    if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ready=%b err=%b data=%h, need 0/0/00000000", PREADY, PSLVERR, PRDATA);
    end
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(1'b1, 32'd7, 32'hC0FFEE11, 1'b0, rd, er, lat, sr);
    model[7] = 32'hC0FFEE11;
    xfer(1'b0, 32'd7, 32'h0, 1'b0, rd, er, lat, sr);
    vectors++;
    if (rd !== 32'hC0FFEE11) begin
      miscompares++;
      $display("FAIL reset_preload_read: got %h, need c0ffee11", rd);
    end
    // Reset asserted inside the access phase of a write to addr 4
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'd4; PWDATA = 32'h5555AAAA;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK); #1;
    PRESETn = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_midxfer: got ready=%b err=%b data=%h, need 0/0/00000000", PREADY, PSLVERR, PRDATA);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    @(posedge PCLK); #1;
    xfer(1'b0, 32'd4, 32'h0, 1'b0, rd, er, lat, sr);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_discard_write: got data=%h err=%b, need 00000000/0", rd, er);
    end
    xfer(1'b0, 32'd7, 32'h0, 1'b0, rd, er, lat, sr);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_clears_mem: got %h, need 00000000", rd);
    end
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int lat; logic sr;
    xfer(1'b1, 32'd3, 32'hDEADBEEF, 1'b0, rd, er, lat, sr);
    model[3] = 32'hDEADBEEF;
    vectors++;
    if (er !== 1'b0 || lat !== WAITS) begin
      miscompares++;
      $display("FAIL basic_write: got err=%b waits=%0d, need 0/%0d", er, lat, WAITS);
    end
    xfer(1'b0, 32'd3, 32'h0, 1'b0, rd, er, lat, sr);
    vectors++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== WAITS) begin
      miscompares++;
      $display("FAIL basic_read: got data=%h err=%b waits=%0d, need deadbeef/0/%0d", rd, er, lat, WAITS);
    end
  endtask

  task automatic test_latency();
    logic [31:0] rd; logic er; int lat; logic sr;
    xfer(1'b0, 32'd5, 32'h0, 1'b0, rd, er, lat, sr);
    vectors++;
    if (lat + 2 !== WAITS + 2 || rd !== model_read(32'd5) || sr !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_read5: got cycles=%0d data=%h setup_ready=%b, need %0d/%h/0",
               lat + 2, rd, sr, WAITS + 2, model_read(32'd5));
    end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic er; int lat; logic sr;
    xfer(1'b1, 32'd16, 32'h12345678, 1'b0, rd, er, lat, sr);
    vectors++;
    if (er !== 1'b1 || lat !== WAITS) begin
      miscompares++;
      $display("FAIL err_write16: got err=%b waits=%0d, need 1/%0d", er, lat, WAITS);
    end
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b0, 32'(i), 32'h0, 1'b0, rd, er, lat, sr);
      vectors++;
      if (rd !== model[i] || er !== 1'b0) begin
        miscompares++;
        $display("FAIL err_unchanged[%0d]: got data=%h err=%b, need %h/0", i, rd, er, model[i]);
      end
    end
    xfer(1'b0, 32'h80000000, 32'h0, 1'b0, rd, er, lat, sr);
    vectors++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      miscompares++;
      $display("FAIL err_read_high: got data=%h err=%b, need 00000000/1", rd, er);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat; logic sr;
    xfer(1'b1, 32'd1, 32'hA5A5A5A5, 1'b1, rd, er, lat, sr);
    model[1] = 32'hA5A5A5A5;
    xfer(1'b0, 32'd1, 32'h0, 1'b0, rd, er, lat, sr);
    vectors++;
    if (rd !== 32'hA5A5A5A5 || er !== 1'b0 || lat !== WAITS || sr !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_read: got data=%h err=%b waits=%0d setup_ready=%b, need a5a5a5a5/0/%0d/0",
               rd, er, lat, sr, WAITS);
    end
  endtask

  task automatic test_psel_drop();
    logic [31:0] rd; logic er; int lat; logic sr;
    logic exp_rdy;
    int pulses;
    xfer(1'b1, 32'd2, 32'h0BADF00D, 1'b0, rd, er, lat, sr);
    model[2] = 32'h0BADF00D;
    exp_rdy = (WAITS == 0);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'd2; PWDATA = 32'h77777777;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b1;
    @(negedge PCLK);
    vectors++;
    if (PREADY !== exp_rdy) begin
      miscompares++;
      $display("FAIL drop_first_access: got ready=%b, need %b", PREADY, exp_rdy);
    end
    pulses = 0;
    repeat (4) begin
      @(negedge PCLK);
      if (PREADY !== 1'b0) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL drop_no_ready: got %0d ready cycles, need 0", pulses);
    end
    @(posedge PCLK); #1;
    PENABLE = 1'b0;
    xfer(1'b0, 32'd2, 32'h0, 1'b0, rd, er, lat, sr);
    vectors++;
    if (rd !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL drop_mem_kept: got %h, need 0badf00d", rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d, exp_rd; logic er, wr, hold, exp_er; int lat; logic sr;
    for (int i = 0; i < 60; i++) begin
      wr   = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 3));
      d    = $urandom;
      hold = (i < 59) && ($urandom_range(0, 1) == 1);
      exp_er = !in_range(a);
      exp_rd = (wr || exp_er) ? 32'h0 : model_read(a);
      xfer(wr, a, d, hold, rd, er, lat, sr);
      if (wr && !exp_er) model[a[3:0]] = d;
      vectors++;
      if (rd !== exp_rd || er !== exp_er || lat !== WAITS || sr !== 1'b0) begin
        miscompares++;
        $display("FAIL random[%0d] wr=%b addr=%h: got data=%h err=%b waits=%0d setup_ready=%b, need %h/%b/%0d/0",
                 i, wr, a, rd, er, lat, sr, exp_rd, exp_er, WAITS);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #2 PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    test_reset();
    test_basic();
    test_latency();
    test_error();
    test_back_to_back();
    test_psel_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
